uart_cmd_parser: RTL and testbench

Byte-level command framer sitting directly downstream of the UART receiver. Consumes received bytes and their completion flag, assembles fixed 6-byte command frames (sync, opcode, address, 16-bit data, XOR checksum), and issues single-cycle register read/write requests to the on-chip register bank. Malformed, corrupted or stalled frames are dropped and reported through an error pulse and code.

---
 rtl/uart_cmd_parser.sv | 131 +++++++++++++
 tb/tb_uart_cmd_parser.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Command framer behind the UART receiver. It assembles 6-byte frames (sync, opcode, address,
// data hi, data lo, XOR checksum) and issues one-cycle register read/write requests or an error pulse.
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic [7:0] OP_WRITE       = 8'h01,
    parameter logic [7:0] OP_READ        = 8'h02,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        wr_en,
    output logic        rd_en,
    output logic [7:0]  addr,
    output logic [15:0] wdata,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] ERR_OPCODE   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DHI, DLO, CHK} state_t;

    state_t           state;
    logic             rx_valid_q;
    logic             byte_stb;
    logic [CNT_W-1:0] idle_cnt;
    logic             is_write;
    logic [7:0]       chk;
    logic [7:0]       addr_sh;
    logic [7:0]       dhi_sh;
    logic [7:0]       dlo_sh;

    assign byte_stb = rx_valid & ~rx_valid_q;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            // NOTE: rx_valid_q resets to 1 so a level held high through reset is not taken as a new byte.
            rx_valid_q <= 1'b1;
            idle_cnt   <= '0;
            is_write   <= 1'b0;
            chk        <= '0;
            addr_sh    <= '0;
            dhi_sh     <= '0;
            dlo_sh     <= '0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= 2'b00;
            addr       <= '0;
            wdata      <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every read sees the pre-edge value.
            rx_valid_q <= rx_valid;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            frame_err  <= 1'b0;

            if (state == IDLE || byte_stb)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;

            if (byte_stb) begin
                case (state)
                    IDLE: begin
                        if (rx_byte == SYNC_BYTE)
                            state <= CMD;
                    end
                    CMD: begin
                        if (rx_byte == OP_WRITE || rx_byte == OP_READ) begin
                            is_write <= (rx_byte == OP_WRITE);
                            chk      <= rx_byte;
                            state    <= ADDR;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_OPCODE;
                            state     <= IDLE;
                        end
                    end
                    ADDR: begin
                        addr_sh <= rx_byte;
                        chk     <= chk ^ rx_byte;
                        state   <= DHI;
                    end
                    DHI: begin
                        dhi_sh <= rx_byte;
                        chk    <= chk ^ rx_byte;
                        state  <= DLO;
                    end
                    DLO: begin
                        dlo_sh <= rx_byte;
                        chk    <= chk ^ rx_byte;
                        state  <= CHK;
                    end
                    CHK: begin
                        if (rx_byte == chk) begin
                            addr <= addr_sh;
                            if (is_write) begin
                                wdata <= {dhi_sh, dlo_sh};
                                wr_en <= 1'b1;
                            end else begin
                                rd_en <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CHECKSUM;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && idle_cnt == CNT_LAST) begin
                // A strobe in the same cycle takes the branch above, so a late byte beats the timeout.
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                state     <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: frame-level reference model compared every cycle,
// plus literal expectations per directed scenario.
module tb_uart_cmd_parser;

    localparam int T = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_byte = 8'h00;
    logic        rx_valid = 1'b0;
    logic        wr_en, rd_en, frame_err, busy;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    uart_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
        .frame_err(frame_err), .err_code(err_code), .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: collects bytes of the current frame and judges the whole frame at once.
    logic [7:0]  frame_q[$];
    int          idle_cycles = 0;
    bit          prev_valid = 1'b1;
    logic        m_wr = 1'b0, m_rd = 1'b0, m_err = 1'b0, m_busy = 1'b0;
    logic [1:0]  m_code = 2'b00;
    logic [7:0]  m_addr = 8'h00;
    logic [15:0] m_wdata = 16'h0000;

    always @(posedge clk) begin : model
        bit stb;
        if (reset) begin
            frame_q.delete();
            idle_cycles = 0;
            prev_valid  = 1'b1;
            m_wr = 1'b0; m_rd = 1'b0; m_err = 1'b0; m_busy = 1'b0;
            m_code = 2'b00; m_addr = 8'h00; m_wdata = 16'h0000;
        end else begin
            stb = rx_valid && !prev_valid;
            prev_valid = rx_valid;
            m_wr = 1'b0; m_rd = 1'b0; m_err = 1'b0;
            if (stb) begin
                idle_cycles = 0;
                if (frame_q.size() == 0) begin
                    if (rx_byte == 8'hA5) frame_q.push_back(rx_byte);
                end else begin
                    frame_q.push_back(rx_byte);
                    if (frame_q.size() == 2 && rx_byte != 8'h01 && rx_byte != 8'h02) begin
                        m_err = 1'b1; m_code = 2'b10; frame_q.delete();
                    end else if (frame_q.size() == 6) begin
                        if ((frame_q[1] ^ frame_q[2] ^ frame_q[3] ^ frame_q[4]) == frame_q[5]) begin
                            m_addr = frame_q[2];
                            if (frame_q[1] == 8'h01) begin
                                m_wr = 1'b1;
                                m_wdata = {frame_q[3], frame_q[4]};
                            end else begin
                                m_rd = 1'b1;
                            end
                        end else begin
                            m_err = 1'b1; m_code = 2'b01;
                        end
                        frame_q.delete();
                    end
                end
            end else if (frame_q.size() != 0) begin
                idle_cycles++;
                if (idle_cycles == T) begin
                    m_err = 1'b1; m_code = 2'b11; frame_q.delete();
                end
            end
            m_busy = (frame_q.size() != 0);
        end
    end

    // Per-cycle comparison against the model, and pulse counters for the literal checks.
    int n_wr = 0, n_rd = 0, n_err = 0;

    always @(negedge clk) begin
        if (check_en) begin
            check("wr_en", 32'(wr_en), 32'(m_wr));
            check("rd_en", 32'(rd_en), 32'(m_rd));
            check("frame_err", 32'(frame_err), 32'(m_err));
            check("err_code", 32'(err_code), 32'(m_code));
            check("busy", 32'(busy), 32'(m_busy));
            check("addr", 32'(addr), 32'(m_addr));
            check("wdata", 32'(wdata), 32'(m_wdata));
            check("one_hot_pulse", 32'(32'(wr_en) + 32'(rd_en) + 32'(frame_err) <= 1), 1);
        end
        if (!reset) begin
            n_wr  += int'(wr_en);
            n_rd  += int'(rd_en);
            n_err += int'(frame_err);
        end
    end

    int b_wr, b_rd, b_err;

    task automatic snap();
        b_wr = n_wr; b_rd = n_rd; b_err = n_err;
    endtask

    task automatic expect_pulses(input string tag, input int wr, input int rd, input int er);
        check({tag, "_wr_pulses"}, 32'(n_wr - b_wr), 32'(wr));
        check({tag, "_rd_pulses"}, 32'(n_rd - b_rd), 32'(rd));
        check({tag, "_err_pulses"}, 32'(n_err - b_err), 32'(er));
    endtask

    // Called at a negedge; the strobe lands on the following posedge.
    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        rx_byte  = b;
        rx_valid = 1'b1;
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [47:0] f, input int n, input int hold, input int gap);
        for (int i = 0; i < n; i++)
            send_byte(f[47 - 8*i -: 8], hold, gap);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_en = 1'b1;
        check("reset_busy", 32'(busy), 0);
        check("reset_addr", 32'(addr), 0);
        check("reset_wdata", 32'(wdata), 0);
        check("reset_err_code", 32'(err_code), 0);
        reset = 1'b0;
        @(negedge clk);

        // Write frame, slow level-held bytes.
        snap();
        send_frame(48'hA5_01_10_12_34_37, 6, 50, 5);
        repeat (3) @(negedge clk);
        expect_pulses("write", 1, 0, 0);
        check("write_addr", 32'(addr), 'h10);
        check("write_wdata", 32'(wdata), 'h1234);

        // Read frame leaves wdata alone.
        snap();
        send_frame(48'hA5_02_3C_00_00_3E, 6, 3, 3);
        repeat (3) @(negedge clk);
        expect_pulses("read", 0, 1, 0);
        check("read_addr", 32'(addr), 'h3C);
        check("read_wdata", 32'(wdata), 'h1234);

        // Bad checksum, then a good frame.
        snap();
        send_frame(48'hA5_01_10_12_34_00, 6, 2, 2);
        repeat (3) @(negedge clk);
        expect_pulses("badchk", 0, 0, 1);
        check("badchk_code", 32'(err_code), 'h1);
        check("badchk_addr", 32'(addr), 'h3C);
        check("badchk_wdata", 32'(wdata), 'h1234);
        snap();
        send_frame(48'hA5_01_20_AB_CD_47, 6, 2, 2);
        repeat (3) @(negedge clk);
        expect_pulses("afterchk", 1, 0, 0);
        check("afterchk_addr", 32'(addr), 'h20);
        check("afterchk_wdata", 32'(wdata), 'hABCD);

        // Bad opcode, then junk in IDLE.
        snap();
        send_frame(48'hA5_07_00_00_00_00, 2, 2, 2);
        check("badop_code", 32'(err_code), 'h2);
        check("badop_busy", 32'(busy), 0);
        send_frame(48'h55_AA_00_00_00_00, 2, 2, 2);
        repeat (3) @(negedge clk);
        expect_pulses("badop_junk", 0, 0, 1);

        // Sync value inside a frame is plain data.
        snap();
        send_frame(48'hA5_01_A5_A5_A5_A4, 6, 1, 2);
        repeat (3) @(negedge clk);
        expect_pulses("insync", 1, 0, 0);
        check("insync_addr", 32'(addr), 'hA5);
        check("insync_wdata", 32'(wdata), 'hA5A5);

        // Fast back-to-back frames at the minimum strobe spacing.
        snap();
        send_frame(48'hA5_01_05_00_FF_FB, 6, 1, 1);
        send_frame(48'hA5_02_05_11_22_34, 6, 1, 1);
        repeat (3) @(negedge clk);
        expect_pulses("b2b", 1, 1, 0);
        check("b2b_addr", 32'(addr), 'h05);
        check("b2b_wdata", 32'(wdata), 'h00FF);

        // Timeout: silence after opcode.
        snap();
        send_byte(8'hA5, 1, 1);
        send_byte(8'h01, 1, 0);
        repeat (T + 20) @(negedge clk);
        expect_pulses("timeout", 0, 0, 1);
        check("timeout_code", 32'(err_code), 'h3);
        check("timeout_busy", 32'(busy), 0);

        // Next byte lands 99 cycles after the opcode strobe: frame survives.
        snap();
        send_byte(8'hA5, 1, 1);
        send_byte(8'h01, 1, 0);
        repeat (T - 2) @(negedge clk);
        send_frame(48'h10_56_78_3F_00_00, 4, 1, 1);
        repeat (3) @(negedge clk);
        expect_pulses("alive", 1, 0, 0);
        check("alive_addr", 32'(addr), 'h10);
        check("alive_wdata", 32'(wdata), 'h5678);

        // Reset mid-frame with rx_valid held high across it.
        snap();
        send_byte(8'hA5, 2, 2);
        send_byte(8'h01, 2, 2);
        rx_byte  = 8'h10;
        rx_valid = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_addr", 32'(addr), 0);
        check("rst_wdata", 32'(wdata), 0);
        check("rst_err_code", 32'(err_code), 0);
        rx_valid = 1'b0;
        @(negedge clk);
        send_frame(48'hA5_02_77_00_00_75, 6, 2, 2);
        repeat (3) @(negedge clk);
        expect_pulses("rst", 0, 1, 0);
        check("rst_after_addr", 32'(addr), 'h77);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
